ccr_context_ctrl: RTL and testbench

// - Sequences condition-code context across interrupts: drains pending flag writers, pushes CCR onto a

---
 rtl/ccr_context_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ccr_context_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccr_context_ctrl.sv
// ccr_context_ctrl
// Condition-code context sequencer. On interrupt it waits for in-flight flag
// writers to retire, pushes the CCR onto a small shadow stack and steers fetch
// to the vector. On RTI it pops the stack and drives the CCR load port.
// All outputs come straight from flops so they are glitch-free toward the
// PC mux, the pipeline flush network and the CCR register.

module ccr_context_ctrl #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              rti_wb,
    input  logic              pipe_busy,
    input  logic [FLAG_W-1:0] ccr_reg,
    output logic              stall_fetch,
    output logic              flush,
    output logic              vector_sel,
    output logic              int_ack,
    output logic              ccr_load,
    output logic [FLAG_W-1:0] ccr_load_val,
    output logic [DW-1:0]     depth,
    output logic              ovf_err,
    output logic              unf_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_SAVE    = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_RESTORE = 3'd4
    } state_t;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_C     = DW'(1'b1);
    localparam logic [DW-1:0] ZERO_C    = {DW{1'b0}};

    state_t            state_r;
    state_t            state_s;
    logic              rti_pend_r;
    logic              rti_pend_s;
    logic              ovf_err_r;
    logic              ovf_err_s;
    logic              unf_err_r;
    logic              unf_err_s;
    logic [DW-1:0]     depth_r;
    logic [DW-1:0]     depth_s;
    logic              push_s;
    logic [FLAG_W-1:0] top_s;
    logic [FLAG_W-1:0] stack_r [DEPTH];

    logic              stall_s;
    logic              vector_s;
    logic              load_s;
    logic [FLAG_W-1:0] load_val_s;

    // Select the top-of-stack entry (entry depth-1) for a pending restore.
    always_comb begin
        top_s = {FLAG_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_r == DW'(i + 1)) begin
                top_s = stack_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end

    // Next-state, stack-pointer and sticky-error logic.
    always_comb begin
        state_s    = state_r;
        rti_pend_s = rti_pend_r;
        ovf_err_s  = ovf_err_r;
        unf_err_s  = unf_err_r;
        depth_s    = depth_r;
        push_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rti_pend_r || rti_wb) begin
                    // A pending RTI is consumed now; an RTI arriving on top of
                    // it cannot be queued and marks the program as broken.
                    rti_pend_s = 1'b0;
                    if (rti_pend_r && rti_wb) begin
                        unf_err_s = 1'b1;
                    end else begin
                        unf_err_s = unf_err_r;
                    end
                    if (depth_r != ZERO_C) begin
                        state_s = ST_RESTORE;
                    end else begin
                        unf_err_s = 1'b1;
                    end
                end else if (int_req) begin
                    if (depth_r < DEPTH_MAX) begin
                        state_s = ST_DRAIN;
                    end else begin
                        ovf_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_s = ST_SAVE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_SAVE: begin
                push_s  = 1'b1;
                depth_s = depth_r + ONE_C;
                state_s = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_s = ST_IDLE;
            end
            ST_RESTORE: begin
                depth_s = depth_r - ONE_C;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // RTI seen while busy is remembered for the next IDLE; only one fits.
        if ((state_r != ST_IDLE) && rti_wb) begin
            if (rti_pend_r) begin
                unf_err_s = 1'b1;
            end else begin
                rti_pend_s = 1'b1;
            end
        end else begin
            rti_pend_s = rti_pend_s;
        end
    end

    // Decode the outputs for the state being entered so they can be registered.
    always_comb begin
        stall_s    = 1'b0;
        vector_s   = 1'b0;
        load_s     = 1'b0;
        load_val_s = {FLAG_W{1'b0}};
        case (state_s)
            ST_DRAIN:   stall_s  = 1'b1;
            ST_SAVE:    stall_s  = 1'b1;
            ST_VECTOR:  vector_s = 1'b1;
            ST_RESTORE: begin
                load_s     = 1'b1;
                load_val_s = top_s;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Control state, stack pointer, sticky errors and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rti_pend_r   <= 1'b0;
            ovf_err_r    <= 1'b0;
            unf_err_r    <= 1'b0;
            depth_r      <= ZERO_C;
            stall_fetch  <= 1'b0;
            flush        <= 1'b0;
            vector_sel   <= 1'b0;
            int_ack      <= 1'b0;
            ccr_load     <= 1'b0;
            ccr_load_val <= {FLAG_W{1'b0}};
        end else begin
            state_r      <= state_s;
            rti_pend_r   <= rti_pend_s;
            ovf_err_r    <= ovf_err_s;
            unf_err_r    <= unf_err_s;
            depth_r      <= depth_s;
            stall_fetch  <= stall_s;
            flush        <= vector_s;
            vector_sel   <= vector_s;
            int_ack      <= vector_s;
            ccr_load     <= load_s;
            ccr_load_val <= load_val_s;
        end
    end

    // Shadow stack storage: write the live CCR at the current depth on SAVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {FLAG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (depth_r == DW'(i))) begin
                    stack_r[i] <= ccr_reg;
                end else begin
                    stack_r[i] <= stack_r[i];
                end
            end
        end
    end

    assign depth   = depth_r;
    assign ovf_err = ovf_err_r;
    assign unf_err = unf_err_r;

endmodule

// File: tb/tb_ccr_context_ctrl.sv
// Testbench for ccr_context_ctrl: randomized interrupt / RTI traffic checked
// against a LIFO reference (queue) plus the latency rules of the sequencer.

module tb_ccr_context_ctrl;

    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int DW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              int_req;
    logic              rti_wb;
    logic              pipe_busy;
    logic [FLAG_W-1:0] ccr_reg;
    logic              stall_fetch;
    logic              flush;
    logic              vector_sel;
    logic              int_ack;
    logic              ccr_load;
    logic [FLAG_W-1:0] ccr_load_val;
    logic [DW-1:0]     depth;
    logic              ovf_err;
    logic              unf_err;

    int errors = 0;
    int checks = 0;

    // Reference model: saved contexts as a LIFO plus sticky error flags.
    logic [FLAG_W-1:0] mq[$];
    logic              m_ovf;
    logic              m_unf;

    ccr_context_ctrl #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .rti_wb(rti_wb),
        .pipe_busy(pipe_busy), .ccr_reg(ccr_reg), .stall_fetch(stall_fetch),
        .flush(flush), .vector_sel(vector_sel), .int_ack(int_ack),
        .ccr_load(ccr_load), .ccr_load_val(ccr_load_val), .depth(depth),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise int_req for one cycle with pipe_busy held for 'busy' cycles, then
    // observe for up to 'bound' cycles (stops one cycle after the ack).
    task automatic do_interrupt(input logic [FLAG_W-1:0] val, input int busy, input int bound,
                                output int ack_cyc, output int ack_cnt, output int stall_cnt,
                                output int vec_ok, output int load_cnt);
        ack_cyc = 0; ack_cnt = 0; stall_cnt = 0; vec_ok = 0; load_cnt = 0;
        ccr_reg   = val;
        int_req   = 1'b1;
        pipe_busy = (busy > 0);
        for (int k = 1; k <= bound; k++) begin
            tick;
            if (k == 1) int_req = 1'b0;
            if (k >= busy) pipe_busy = 1'b0;
            if (stall_fetch) stall_cnt++;
            if (ccr_load) load_cnt++;
            if (int_ack && flush && vector_sel && !stall_fetch) vec_ok++;
            if (int_ack) begin
                ack_cnt++;
                if (ack_cyc == 0) ack_cyc = k;
            end
            if (ack_cyc != 0 && k > ack_cyc) break;
        end
    endtask

    // Pulse rti_wb and capture the load port one cycle later.
    task automatic do_rti(output logic load_seen, output logic [FLAG_W-1:0] val);
        rti_wb = 1'b1;
        tick;
        rti_wb = 1'b0;
        load_seen = ccr_load;
        val = ccr_load_val;
        tick;
    endtask

    function automatic int exp_ack(input int busy);
        return ((busy > 1) ? busy : 1) + 2;
    endfunction

    task automatic test_reset;
        rst = 1'b1; int_req = 1'b0; rti_wb = 1'b0; pipe_busy = 1'b0; ccr_reg = 4'h0;
        #23;
        rst = 1'b0;
        tick;
        checks++;
        if ({stall_fetch, flush, vector_sel, int_ack, ccr_load} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got=%b want=00000", {stall_fetch, flush, vector_sel, int_ack, ccr_load});
        end
        checks++;
        if (depth !== 3'd0 || ccr_load_val !== 4'h0) begin
            errors++; $display("FAIL reset_depth got depth=%0d val=%h want 0/0", depth, ccr_load_val);
        end
        checks++;
        if ({ovf_err, unf_err} !== 2'b00) begin
            errors++; $display("FAIL reset_err got=%b want=00", {ovf_err, unf_err});
        end
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic test_int_basic;
        int ac, an, sc, vo, lc;
        do_interrupt(4'b1010, 0, 20, ac, an, sc, vo, lc);
        mq.push_back(4'b1010);
        checks++;
        if (ac !== 3 || an !== 1) begin
            errors++; $display("FAIL basic_ack got cyc=%0d cnt=%0d want 3/1", ac, an);
        end
        checks++;
        if (sc !== 2 || vo !== 1 || lc !== 0) begin
            errors++; $display("FAIL basic_ctrl got stall=%0d vec=%0d load=%0d want 2/1/0", sc, vo, lc);
        end
        checks++;
        if (depth !== DW'(mq.size())) begin
            errors++; $display("FAIL basic_depth got=%0d want=%0d", depth, mq.size());
        end
    endtask

    task automatic test_drain_busy;
        int ac, an, sc, vo, lc, b;
        logic [FLAG_W-1:0] v;
        for (int t = 0; t < 2; t++) begin
            b = (t == 0) ? 5 : $urandom_range(2, 8);
            v = FLAG_W'($urandom);
            do_interrupt(v, b, 30, ac, an, sc, vo, lc);
            mq.push_back(v);
            checks++;
            if (sc !== b + 1 || ac !== exp_ack(b)) begin
                errors++; $display("FAIL drain_busy%0d got stall=%0d ack=%0d want %0d/%0d", b, sc, ac, b + 1, exp_ack(b));
            end
            checks++;
            if (depth !== DW'(mq.size())) begin
                errors++; $display("FAIL drain_depth got=%0d want=%0d", depth, mq.size());
            end
        end
    endtask

    task automatic pop_check(input string name);
        logic ls;
        logic [FLAG_W-1:0] lv;
        logic [FLAG_W-1:0] ev;
        do_rti(ls, lv);
        if (mq.size() > 0) begin
            ev = mq.pop_back();
            checks++;
            if (ls !== 1'b1 || lv !== ev) begin
                errors++; $display("FAIL %s_pop got load=%b val=%h want 1/%h", name, ls, lv, ev);
            end
        end else begin
            m_unf = 1'b1;
            checks++;
            if (ls !== 1'b0 || lv !== 4'h0) begin
                errors++; $display("FAIL %s_unf_load got load=%b val=%h want 0/0", name, ls, lv);
            end
        end
        checks++;
        if (depth !== DW'(mq.size()) || unf_err !== m_unf) begin
            errors++; $display("FAIL %s_state got depth=%0d unf=%b want %0d/%b", name, depth, unf_err, mq.size(), m_unf);
        end
    endtask

    task automatic test_nested_restore;
        int ac, an, sc, vo, lc;
        while (mq.size() > 0) pop_check("unwind");
        do_interrupt(4'b0001, 0, 20, ac, an, sc, vo, lc);
        mq.push_back(4'b0001);
        do_interrupt(4'b0010, 0, 20, ac, an, sc, vo, lc);
        mq.push_back(4'b0010);
        checks++;
        if (depth !== 3'd2) begin
            errors++; $display("FAIL nested_depth got=%0d want=2", depth);
        end
        pop_check("nested1");
        pop_check("nested2");
    endtask

    task automatic test_rti_in_drain;
        int ack1, ack2, ld_cyc;
        logic [FLAG_W-1:0] v1, v2, ld_val;
        ack1 = 0; ack2 = 0; ld_cyc = 0; ld_val = 4'h0;
        v1 = FLAG_W'($urandom); v2 = ~v1;
        ccr_reg = v1; int_req = 1'b1; pipe_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            rti_wb = (k == 1);
            if (k >= 3) pipe_busy = 1'b0;
            if (ccr_load && ld_cyc == 0) begin ld_cyc = k; ld_val = ccr_load_val; end
            if (int_ack) begin
                if (ack1 == 0) begin ack1 = k; ccr_reg = v2; end
                else if (ack2 == 0) begin ack2 = k; int_req = 1'b0; end
            end
            if (ack2 != 0 && k > ack2) break;
        end
        int_req = 1'b0; rti_wb = 1'b0;
        mq.push_back(v1);
        v1 = mq.pop_back();
        mq.push_back(v2);
        checks++;
        if (ack1 !== 5 || ld_cyc !== 7 || ack2 !== 11) begin
            errors++; $display("FAIL rti_drain_order got ack1=%0d load=%0d ack2=%0d want 5/7/11", ack1, ld_cyc, ack2);
        end
        checks++;
        if (ld_val !== v1) begin
            errors++; $display("FAIL rti_drain_val got=%h want=%h", ld_val, v1);
        end
        checks++;
        if (depth !== DW'(mq.size())) begin
            errors++; $display("FAIL rti_drain_depth got=%0d want=%0d", depth, mq.size());
        end
    endtask

    task automatic test_overflow;
        int ac, an, sc, vo, lc;
        logic [FLAG_W-1:0] v;
        while (mq.size() < DEPTH) begin
            v = FLAG_W'($urandom);
            do_interrupt(v, $urandom_range(0, 3), 30, ac, an, sc, vo, lc);
            mq.push_back(v);
        end
        checks++;
        if (depth !== 3'd4 || ovf_err !== 1'b0) begin
            errors++; $display("FAIL ovf_fill got depth=%0d ovf=%b want 4/0", depth, ovf_err);
        end
        do_interrupt(4'hF, 0, 8, ac, an, sc, vo, lc);
        m_ovf = 1'b1;
        checks++;
        if (an !== 0 || sc !== 0) begin
            errors++; $display("FAIL ovf_ack got acks=%0d stalls=%0d want 0/0", an, sc);
        end
        checks++;
        if (ovf_err !== 1'b1 || depth !== 3'd4) begin
            errors++; $display("FAIL ovf_flag got ovf=%b depth=%0d want 1/4", ovf_err, depth);
        end
    endtask

    task automatic test_underflow;
        while (mq.size() > 0) pop_check("lifo");
        checks++;
        if (unf_err !== 1'b0) begin
            errors++; $display("FAIL unf_pre got=%b want=0", unf_err);
        end
        pop_check("underflow");
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got=%b want=1", ovf_err);
        end
    endtask

    task automatic test_random;
        int ac, an, sc, vo, lc, b;
        logic [FLAG_W-1:0] v;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                v = FLAG_W'($urandom);
                b = $urandom_range(0, 4);
                if (mq.size() < DEPTH) begin
                    do_interrupt(v, b, 30, ac, an, sc, vo, lc);
                    mq.push_back(v);
                    checks++;
                    if (ac !== exp_ack(b) || an !== 1 || vo !== 1) begin
                        errors++; $display("FAIL rand_push%0d got ack=%0d cnt=%0d vec=%0d want %0d/1/1", n, ac, an, vo, exp_ack(b));
                    end
                end else begin
                    do_interrupt(v, b, 8, ac, an, sc, vo, lc);
                    m_ovf = 1'b1;
                    checks++;
                    if (an !== 0) begin
                        errors++; $display("FAIL rand_ovf%0d got acks=%0d want 0", n, an);
                    end
                end
                checks++;
                if (depth !== DW'(mq.size()) || ovf_err !== m_ovf) begin
                    errors++; $display("FAIL rand_state%0d got depth=%0d ovf=%b want %0d/%b", n, depth, ovf_err, mq.size(), m_ovf);
                end
            end else begin
                pop_check("rand");
            end
        end
    endtask

    task automatic test_reset_mid;
        int ac, an, sc, vo, lc;
        ccr_reg = FLAG_W'($urandom); int_req = 1'b1; pipe_busy = 1'b1;
        tick;
        int_req = 1'b0;
        tick;
        checks++;
        if (stall_fetch !== 1'b1) begin
            errors++; $display("FAIL rstmid_drain got stall=%b want=1", stall_fetch);
        end
        #2 rst = 1'b1;
        #1;
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        checks++;
        if (stall_fetch !== 1'b0 || depth !== 3'd0 || {ovf_err, unf_err} !== 2'b00) begin
            errors++; $display("FAIL rstmid_async got stall=%b depth=%0d err=%b want 0/0/00", stall_fetch, depth, {ovf_err, unf_err});
        end
        tick; tick;
        #2 rst = 1'b0;
        pipe_busy = 1'b0;
        tick; tick;
        checks++;
        if ({stall_fetch, flush, int_ack, ccr_load} !== 4'b0000 || depth !== 3'd0) begin
            errors++; $display("FAIL rstmid_idle got ctrl=%b depth=%0d want 0000/0", {stall_fetch, flush, int_ack, ccr_load}, depth);
        end
        do_interrupt(4'b0110, 0, 20, ac, an, sc, vo, lc);
        mq.push_back(4'b0110);
        checks++;
        if (ac !== 3 || depth !== DW'(mq.size())) begin
            errors++; $display("FAIL rstmid_after got ack=%0d depth=%0d want 3/%0d", ac, depth, mq.size());
        end
    endtask

    initial begin
        test_reset();
        test_int_basic();
        test_drain_busy();
        test_nested_restore();
        test_rti_in_drain();
        test_overflow();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
